// File: rtl/sort_engine.sv
// In-place bubble sorter for an async-read / sync-write distributed RAM.
// Sorts entries 0..n_last ascending or descending and stops early after a pass with no swap.
//
// state | meaning
// IDLE  | waiting for start; mem_a=0, mem_we=0
// RD    | read entry i into x
// CMP   | read entry i+1 into y; on swap write x to i+1
// WB    | write y to i (second half of a swap)
// DONE  | one-cycle done pulse
module sort_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 24
) (
    input  logic              CLK100MHZ,
    input  logic              rstn,
    input  logic              start,
    input  logic              descend,
    input  logic [ADDR_W-1:0] n_last,
    input  logic [DATA_W-1:0] mem_spo,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_WB,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] bound_q, bound_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              swapped_q, swapped_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;

    logic [ADDR_W-1:0] i_nxt;
    logic [CNT_W-1:0]  cycles_inc;
    logic              need;
    logic              advance;

    assign i_nxt      = i_q + ADDR_W'(1);
    assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    // Strict compare: equal neighbours never swap, which keeps the sort stable.
    assign need       = mode_q ? (x_q < mem_spo) : (x_q > mem_spo);
    assign cycles     = cycles_q;

    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            bound_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            swapped_q <= 1'b0;
            mode_q    <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            bound_q   <= bound_d;
            x_q       <= x_d;
            y_q       <= y_d;
            swapped_q <= swapped_d;
            mode_q    <= mode_d;
            cycles_q  <= cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        bound_d   = bound_q;
        x_d       = x_q;
        y_d       = y_q;
        swapped_d = swapped_q;
        mode_d    = mode_q;
        cycles_d  = cycles_q;
        mem_a     = '0;
        mem_d     = '0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        advance   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = descend;
                    bound_d   = n_last;
                    i_d       = '0;
                    swapped_d = 1'b0;
                    cycles_d  = '0;
                    state_d   = (n_last == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                busy     = 1'b1;
                mem_a    = i_q;
                x_d      = mem_spo;
                cycles_d = cycles_inc;
                state_d  = S_CMP;
            end
            S_CMP: begin
                busy     = 1'b1;
                mem_a    = i_nxt;
                y_d      = mem_spo;
                cycles_d = cycles_inc;
                if (need) begin
                    mem_d     = x_q;
                    mem_we    = 1'b1;
                    swapped_d = 1'b1;
                    state_d   = S_WB;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WB: begin
                busy     = 1'b1;
                mem_a    = i_q;
                mem_d    = y_q;
                mem_we   = 1'b1;
                cycles_d = cycles_inc;
                advance  = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // i+1 reaches bound before it could wrap, so n_last = all-ones is safe.
        if (advance) begin
            if (i_nxt != bound_q) begin
                i_d     = i_nxt;
                state_d = S_RD;
            end else if (!swapped_q || bound_q == ADDR_W'(1)) begin
                state_d = S_DONE;
            end else begin
                bound_d   = bound_q - ADDR_W'(1);
                i_d       = '0;
                swapped_d = 1'b0;
                state_d   = S_RD;
            end
        end
    end

endmodule
